// File: rtl/cdclib_pkg.sv
// Shared CDC library definitions: launch FSM states, hold-window sizing and clog2.
package cdclib_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } cdclib_state_t;

  function automatic int cdclib_clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Hold long enough for SYNCSTAGE+1 receive-clock periods, expressed in launch cycles.
  function automatic int cdclib_hold_cycles(input int syncstage, input int wr_mhz,
                                            input int rd_mhz);
    int num;
    int h;
    num = (syncstage + 1) * wr_mhz;
    h   = (num + rd_mhz - 1) / rd_mhz + 1;
    return (h < 2) ? 2 : h;
  endfunction

endpackage

// File: rtl/cdclib_hold_cnt.sv
// Loadable down-counter that stops at zero and flags it; times the launch hold window.
module cdclib_hold_cnt #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [WIDTH-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/cdclib_lvlsync_launch.sv
// Write-domain launch stage of the level-sync path: holds each launched value for HOLD_CYC cycles.
// Optional one-entry pending buffer enabled by defining CDCLIB_LVLSYNC_LAUNCH_PEND_EN.
module cdclib_lvlsync_launch
  import cdclib_pkg::*;
#(
  parameter bit EN_PULSE_MODE   = 1'b0,
  parameter int DWIDTH          = 1,
  parameter int SYNCSTAGE       = 2,
  parameter bit ACTIVE_LEVEL    = 1'b1,
  parameter int WR_CLK_FREQ_MHZ = 250,
  parameter int RD_CLK_FREQ_MHZ = 250
) (
  input  logic              wr_clk,
  input  logic              wr_rst_n,
  input  logic [DWIDTH-1:0] data_in,
  input  logic              data_in_vld,
  output logic              data_in_rdy,
  output logic [DWIDTH-1:0] data_out,
  output logic              busy
);

  localparam int HOLD_CYC = cdclib_hold_cycles(SYNCSTAGE, WR_CLK_FREQ_MHZ, RD_CLK_FREQ_MHZ);
  localparam int CNT_W    = cdclib_clog2(HOLD_CYC + 1);
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(HOLD_CYC - 1);
  localparam logic [DWIDTH-1:0] RST_VAL  = EN_PULSE_MODE ? '0 : {DWIDTH{~ACTIVE_LEVEL}};

  cdclib_state_t state;
  logic          xfer;
  logic          in_chg;
  logic          cnt_zero;
  logic          cnt_load;

  function automatic logic [DWIDTH-1:0] launch_val(input logic [DWIDTH-1:0] cur,
                                                   input logic [DWIDTH-1:0] upd);
    return EN_PULSE_MODE ? (cur ^ upd) : upd;
  endfunction

  assign xfer   = data_in_vld & data_in_rdy;
  assign in_chg = EN_PULSE_MODE ? (|data_in) : (data_in != data_out);
  assign busy   = (state == HOLD);

`ifdef CDCLIB_LVLSYNC_LAUNCH_PEND_EN
  logic              pend_vld;
  logic [DWIDTH-1:0] pend_data;
  logic              merge_vld;
  logic [DWIDTH-1:0] merge_data;
  logic              launch_pend;

  // Pulse events accumulate; pend_data is kept zero whenever pend_vld is clear.
  always_comb begin
    merge_vld  = pend_vld;
    merge_data = pend_data;
    if ((state == HOLD) && xfer) begin
      if (EN_PULSE_MODE) begin
        if (|data_in) begin
          merge_vld  = 1'b1;
          merge_data = pend_data | data_in;
        end
      end else begin
        merge_vld  = 1'b1;
        merge_data = data_in;
      end
    end
  end

  assign launch_pend = merge_vld & (EN_PULSE_MODE ? 1'b1 : (merge_data != data_out));
  assign data_in_rdy = (state == IDLE) | (EN_PULSE_MODE ? 1'b1 : ~pend_vld);
  assign cnt_load    = ((state == IDLE) & xfer & in_chg) |
                       ((state == HOLD) & cnt_zero & launch_pend);
`else
  assign data_in_rdy = (state == IDLE);
  assign cnt_load    = (state == IDLE) & xfer & in_chg;
`endif

  cdclib_hold_cnt #(
    .WIDTH(CNT_W)
  ) u_hold_cnt (
    .clk     (wr_clk),
    .rst_n   (wr_rst_n),
    .load    (cnt_load),
    .load_val(CNT_LOAD),
    .en      (busy),
    .zero    (cnt_zero)
  );

  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      state    <= IDLE;
      data_out <= RST_VAL;
`ifdef CDCLIB_LVLSYNC_LAUNCH_PEND_EN
      pend_vld  <= 1'b0;
      pend_data <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (xfer && in_chg) begin
            data_out <= launch_val(data_out, data_in);
            state    <= HOLD;
          end
        end
        HOLD: begin
`ifdef CDCLIB_LVLSYNC_LAUNCH_PEND_EN
          if (cnt_zero) begin
            // Expiry edge doubles as the launch edge of a pending value.
            if (launch_pend) begin
              data_out <= launch_val(data_out, merge_data);
            end else begin
              state <= IDLE;
            end
            pend_vld  <= 1'b0;
            pend_data <= '0;
          end else begin
            pend_vld  <= merge_vld;
            pend_data <= merge_data;
          end
`else
          if (cnt_zero) begin
            state <= IDLE;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cdclib_lvlsync_launch.sv
// Scoreboard bench for cdclib_lvlsync_launch: three configurations against a timestamp-based window model.
module tb_cdclib_lvlsync_launch;

`ifdef CDCLIB_LVLSYNC_LAUNCH_PEND_EN
  localparam bit PEND = 1'b1;
`else
  localparam bit PEND = 1'b0;
`endif

  logic       clk = 1'b0;
  logic [2:0] rst_n;
  logic [2:0] vld;
  logic [2:0] rdy;
  logic [2:0] busy;
  logic [3:0] din0, din2, dout0, dout2;
  logic [1:0] din1, dout1;

  int edge_n      = 0;
  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  // 0: level, defaults; 1: pulse, 2 bits; 2: level, ACTIVE_LEVEL=0, 500/100 MHz, 3 stages
  cdclib_lvlsync_launch #(
    .EN_PULSE_MODE(1'b0), .DWIDTH(4), .SYNCSTAGE(2), .ACTIVE_LEVEL(1'b1),
    .WR_CLK_FREQ_MHZ(250), .RD_CLK_FREQ_MHZ(250)
  ) u_lvl (
    .wr_clk(clk), .wr_rst_n(rst_n[0]), .data_in(din0), .data_in_vld(vld[0]),
    .data_in_rdy(rdy[0]), .data_out(dout0), .busy(busy[0])
  );

  cdclib_lvlsync_launch #(
    .EN_PULSE_MODE(1'b1), .DWIDTH(2), .SYNCSTAGE(2), .ACTIVE_LEVEL(1'b1),
    .WR_CLK_FREQ_MHZ(250), .RD_CLK_FREQ_MHZ(250)
  ) u_pls (
    .wr_clk(clk), .wr_rst_n(rst_n[1]), .data_in(din1), .data_in_vld(vld[1]),
    .data_in_rdy(rdy[1]), .data_out(dout1), .busy(busy[1])
  );

  cdclib_lvlsync_launch #(
    .EN_PULSE_MODE(1'b0), .DWIDTH(4), .SYNCSTAGE(3), .ACTIVE_LEVEL(1'b0),
    .WR_CLK_FREQ_MHZ(500), .RD_CLK_FREQ_MHZ(100)
  ) u_slow (
    .wr_clk(clk), .wr_rst_n(rst_n[2]), .data_in(din2), .data_in_vld(vld[2]),
    .data_in_rdy(rdy[2]), .data_out(dout2), .busy(busy[2])
  );

  // Hold lengths worked out by hand: ceil(3*250/250)+1 = 4, ceil(4*500/100)+1 = 21
  int         H     [3] = '{4, 4, 21};
  bit         PULSE [3] = '{1'b0, 1'b1, 1'b0};
  logic [3:0] RSTV  [3] = '{4'h0, 4'h0, 4'hF};
  logic [3:0] MASK  [3] = '{4'hF, 4'h3, 4'hF};

  logic [3:0] cur       [3];
  int         win_end   [3];
  bit         pv        [3];
  logic [3:0] pd        [3];
  bit         last_xfer [3];

  typedef struct {
    logic [3:0] val;
    int         at;
  } exp_t;
  exp_t q0[$], q1[$], q2[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: actual %0h required %0h (edge %0d)", name, act, req, edge_n);
    end
  endtask

  function automatic logic [3:0] get_dout(input int i);
    case (i)
      0:       return dout0;
      1:       return {2'b00, dout1};
      default: return dout2;
    endcase
  endfunction

  function automatic logic [3:0] get_din(input int i);
    case (i)
      0:       return din0;
      1:       return {2'b00, din1};
      default: return din2;
    endcase
  endfunction

  task automatic set_din(input int i, input logic [3:0] d);
    case (i)
      0:       din0 = d;
      1:       din1 = d[1:0];
      default: din2 = d;
    endcase
  endtask

  task automatic push_exp(input int i, input exp_t e);
    case (i)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic pop_exp(input int i, output bit ok, output exp_t e);
    ok = 1'b0;
    e  = '{val: 4'h0, at: 0};
    case (i)
      0:       if (q0.size() > 0) begin e = q0.pop_front(); ok = 1'b1; end
      1:       if (q1.size() > 0) begin e = q1.pop_front(); ok = 1'b1; end
      default: if (q2.size() > 0) begin e = q2.pop_front(); ok = 1'b1; end
    endcase
  endtask

  function automatic int q_size(input int i);
    case (i)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic model_reset(input int i);
    cur[i]       = RSTV[i];
    win_end[i]   = 0;
    pv[i]        = 1'b0;
    pd[i]        = 4'h0;
    last_xfer[i] = 1'b0;
    case (i)
      0:       q0.delete();
      1:       q1.delete();
      default: q2.delete();
    endcase
  endtask

  // A value launched at edge n is held through edges n..n+H-1; the window expires at edge n+H.
  task automatic launch(input int i, input logic [3:0] v, input int n);
    exp_t e;
    cur[i]     = v;
    win_end[i] = n + H[i];
    e.val      = v;
    e.at       = n;
    push_exp(i, e);
  endtask

  // Called at a falling edge with inputs already driven; predicts the next rising edge.
  task automatic step();
    for (int i = 0; i < 3; i++) begin
      int         k;
      int         n;
      bit         in_hold;
      bit         erdy;
      bit         xfer;
      logic [3:0] d;
      last_xfer[i] = 1'b0;
      if (rst_n[i]) begin
        k       = edge_n;
        n       = k + 1;
        in_hold = (k < win_end[i]);
        erdy    = !in_hold || (PEND && (PULSE[i] || !pv[i]));
        check($sformatf("rdy%0d", i), rdy[i], erdy);
        check($sformatf("busy%0d", i), busy[i], in_hold);
        xfer         = vld[i] && erdy;
        last_xfer[i] = xfer;
        d            = get_din(i) & MASK[i];
        if (!in_hold) begin
          if (xfer && (PULSE[i] ? (d != 4'h0) : (d != cur[i])))
            launch(i, PULSE[i] ? (cur[i] ^ d) : d, n);
        end else begin
          if (PEND && xfer && (!PULSE[i] || d != 4'h0)) begin
            pv[i] = 1'b1;
            pd[i] = PULSE[i] ? (pd[i] | d) : d;
          end
          if (n == win_end[i]) begin
            if (pv[i] && (PULSE[i] || pd[i] != cur[i]))
              launch(i, PULSE[i] ? (cur[i] ^ pd[i]) : pd[i], n);
            pv[i] = 1'b0;
            pd[i] = 4'h0;
          end
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_mon
    logic [3:0] prev;
    exp_t       e;
    bit         ok;
    always @(posedge clk) begin
      #1;
      if (rst_n[g] && (get_dout(g) !== prev)) begin
        pop_exp(g, ok, e);
        if (!ok) begin
          check($sformatf("spurious_change%0d", g), get_dout(g), prev);
        end else begin
          check($sformatf("out_val%0d", g), get_dout(g), e.val);
          check($sformatf("out_edge%0d", g), edge_n, e.at);
        end
      end
      prev = get_dout(g);
    end
  end

  initial begin
    int cnt;
    int c;
    rst_n = 3'b000;
    vld   = 3'b000;
    din0  = 4'h0;
    din1  = 2'b00;
    din2  = 4'h0;
    for (int i = 0; i < 3; i++) model_reset(i);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 3'b111;
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_dout%0d", i), get_dout(i), RSTV[i]);
      check($sformatf("rst_rdy%0d", i), rdy[i], 1'b1);
      check($sformatf("rst_busy%0d", i), busy[i], 1'b0);
    end
    @(negedge clk);

    // Level mode: A launched, 5 held by the producer until accepted
    vld[0] = 1'b1;
    din0   = 4'hA;
    step();
    check("lvl_first", dout0, 4'hA);
    check("lvl_first_busy", busy[0], 1'b1);
    din0 = 4'h5;
    c    = 0;
    do begin
      step();
      c++;
    end while (!last_xfer[0] && c < 20);
    vld[0] = 1'b0;
    step();
    check("lvl_second", dout0, 4'h5);
    repeat (6) step();
    vld[0] = 1'b1;
    din0   = 4'h5;
    step();
    vld[0] = 1'b0;
    check("lvl_same_busy", busy[0], 1'b0);
    check("lvl_same_val", dout0, 4'h5);
    step();

    // Pulse mode: 01 then 11 -> 00, 01, 10
    vld[1] = 1'b1;
    din1   = 2'b01;
    step();
    check("pls_first", dout1, 2'b01);
`ifdef CDCLIB_LVLSYNC_LAUNCH_PEND_EN
    din1 = 2'b01;
    step();
    din1 = 2'b10;
    step();
    vld[1] = 1'b0;
    din1   = 2'b00;
    repeat (6) step();
`else
    vld[1] = 1'b0;
    repeat (5) step();
    vld[1] = 1'b1;
    din1   = 2'b11;
    step();
    vld[1] = 1'b0;
    repeat (5) step();
`endif
    check("pls_second", dout1, 2'b10);

    // Slow ratio: full 21-cycle window, then async reset mid-window
    vld[2] = 1'b1;
    din2   = 4'h3;
    step();
    vld[2] = 1'b0;
    check("slow_launch", dout2, 4'h3);
    cnt = 0;
    for (int j = 0; j < 30; j++) begin
      if (busy[2]) cnt++;
      step();
    end
    check("slow_busy_len", cnt, 21);
    vld[2] = 1'b1;
    din2   = 4'h9;
    step();
    vld[2] = 1'b0;
    repeat (9) step();
    check("slow_mid_busy", busy[2], 1'b1);
    rst_n[2] = 1'b0;
    #1;
    check("slow_rst_dout", dout2, 4'hF);
    check("slow_rst_busy", busy[2], 1'b0);
    check("slow_rst_rdy", rdy[2], 1'b1);
    model_reset(2);
    @(negedge clk);
    step();
    rst_n[2] = 1'b1;
    step();

    // Random traffic; a refused beat is held unchanged until accepted
    for (int t = 0; t < 600; t++) begin
      for (int i = 0; i < 3; i++) begin
        if (!(vld[i] && !last_xfer[i])) begin
          vld[i] = ($urandom_range(0, 2) != 0);
          if (!PULSE[i] && $urandom_range(0, 3) == 0) set_din(i, cur[i]);
          else set_din(i, 4'($urandom_range(0, 15)) & MASK[i]);
        end
      end
      step();
    end
    vld = 3'b000;
    repeat (30) step();
    for (int i = 0; i < 3; i++) check($sformatf("drain%0d", i), q_size(i), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
